lcd_msg_sequencer: RTL and testbench

//  Drives the DE2-70 16x2 HD44780-compatible character LCD from the message ROM. After power-up it

---
 rtl/lcd_msg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_lcd_msg_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_sequencer.sv
// rtl/lcd_msg_sequencer.sv - HD44780 16x2 LCD writer: power-up wait, init commands, then message ROM bytes.
module lcd_msg_sequencer #(
  parameter int POWERUP_CYC     = 750000,
  parameter int SETUP_CYC       = 4,
  parameter int EN_HIGH_CYC     = 16,
  parameter int DELAY_CYC       = 2000,
  parameter int CLEAR_DELAY_CYC = 82000,
  parameter int LINE_LEN        = 16,
  parameter int MSG_LEN         = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic [5:0]  o_rom_addr,
  input  logic [31:0] i_rom_data,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_done
);

  localparam int MAX_A   = (POWERUP_CYC > CLEAR_DELAY_CYC) ? POWERUP_CYC : CLEAR_DELAY_CYC;
  localparam int MAX_B   = (DELAY_CYC > EN_HIGH_CYC) ? DELAY_CYC : EN_HIGH_CYC;
  localparam int MAX_C   = (SETUP_CYC > MAX_B) ? SETUP_CYC : MAX_B;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLEAR_DELAY_CYC - 1);

  localparam logic [5:0] LINE_END = 6'(LINE_LEN - 1);
  localparam logic [5:0] MSG_END  = 6'(MSG_LEN - 1);

  // Step index walks the byte stream; steps 5 and 7 repeat once per character.
  localparam logic [2:0] ST_FUNC_SET  = 3'd0;
  localparam logic [2:0] ST_DISP_ON   = 3'd1;
  localparam logic [2:0] ST_CLEAR     = 3'd2;
  localparam logic [2:0] ST_ENTRY     = 3'd3;
  localparam logic [2:0] ST_LINE1     = 3'd4;
  localparam logic [2:0] ST_CHAR1     = 3'd5;
  localparam logic [2:0] ST_LINE2     = 3'd6;
  localparam logic [2:0] ST_CHAR2     = 3'd7;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_LOAD,
    S_SETUP,
    S_EN_HI,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_step;
  logic [5:0]       r_rom_addr;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_rs;
  logic             r_lcd_en;
  logic             r_lcd_on;
  logic             r_busy;
  logic             r_done;

  logic       w_step_is_char;
  logic [7:0] w_cmd_byte;
  logic       w_wait_last;
  logic       w_unused_rom;

  assign w_step_is_char = (r_step == ST_CHAR1) || (r_step == ST_CHAR2);
  assign w_unused_rom   = ^i_rom_data[31:8];

  always_comb begin
    w_cmd_byte = 8'h00;
    case (r_step)
      ST_FUNC_SET: w_cmd_byte = 8'h38;
      ST_DISP_ON:  w_cmd_byte = 8'h0C;
      ST_CLEAR:    w_cmd_byte = 8'h01;
      ST_ENTRY:    w_cmd_byte = 8'h06;
      ST_LINE1:    w_cmd_byte = 8'h80;
      ST_LINE2:    w_cmd_byte = 8'hC0;
      default:     w_cmd_byte = 8'h00;
    endcase
  end

  // Clear-display needs the long settle time; a character 0x01 does not.
  assign w_wait_last = (r_lcd_data == 8'h01 && !r_lcd_rs) ? (r_cnt == CLR_LAST)
                                                          : (r_cnt == DLY_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_PWR_WAIT;
      r_cnt      <= '0;
      r_step     <= ST_FUNC_SET;
      r_rom_addr <= 6'd0;
      r_lcd_data <= 8'h00;
      r_lcd_rs   <= 1'b0;
      r_lcd_en   <= 1'b0;
      r_lcd_on   <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_lcd_on <= 1'b1;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_lcd_data <= w_step_is_char ? i_rom_data[7:0] : w_cmd_byte;
          r_lcd_rs   <= w_step_is_char;
          r_cnt      <= '0;
          r_state    <= S_SETUP;
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b1;
            r_state  <= S_EN_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EN_HI: begin
          if (r_cnt == EN_LAST) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_wait_last) begin
            r_cnt <= '0;
            case (r_step)
              ST_CHAR1: begin
                r_rom_addr <= r_rom_addr + 6'd1;
                if (r_rom_addr == LINE_END) r_step <= ST_LINE2;
                r_state <= S_LOAD;
              end
              ST_CHAR2: begin
                if (r_rom_addr == MSG_END) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_rom_addr <= r_rom_addr + 6'd1;
                  r_state    <= S_LOAD;
                end
              end
              default: begin
                r_step  <= r_step + 3'd1;
                r_state <= S_LOAD;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (i_start) begin
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_rom_addr <= 6'd0;
            r_step     <= ST_LINE1;
            r_cnt      <= '0;
            r_state    <= S_LOAD;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_PWR_WAIT;
        end
      endcase
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_lcd_data = r_lcd_data;
  assign o_lcd_rs   = r_lcd_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_lcd_en;
  assign o_lcd_on   = r_lcd_on;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb/tb_lcd_msg_sequencer.sv - self-checking bench for lcd_msg_sequencer.
module tb_lcd_msg_sequencer;

  localparam int P_PWR = 10;
  localparam int P_SET = 2;
  localparam int P_EN  = 4;
  localparam int P_DLY = 8;
  localparam int P_CLR = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done;

  always #5 clk = ~clk;

  assign rom_data = {24'hDEADBE, 8'h41 + {2'b00, rom_addr}};

  lcd_msg_sequencer #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .EN_HIGH_CYC(P_EN), .DELAY_CYC(P_DLY),
    .CLEAR_DELAY_CYC(P_CLR), .LINE_LEN(16), .MSG_LEN(32)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_busy(busy), .o_done(done)
  );

  typedef struct { logic [7:0] data; logic rs; } vec_t;
  typedef struct { logic [7:0] data; logic rs; int rise; int fall; } wr_t;

  vec_t exp_tab[38];
  wr_t  wr_q[$];
  int   cyc = 0;
  int   cur_rise = 0;
  int   done_cyc = 0;
  int   inv_bad = 0;
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic hold_rs = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (busy == done || rom_addr > 6'd31 || lcd_rw !== 1'b0) inv_bad = inv_bad + 1;
    if (!rst_n) begin
      prev_en   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        cur_rise  = cyc;
        hold_data = lcd_data;
        hold_rs   = lcd_rs;
      end
      if (lcd_en && prev_en && (lcd_data != hold_data || lcd_rs != hold_rs)) inv_bad = inv_bad + 1;
      if (!lcd_en && prev_en) begin
        wr_t w;
        w.data = lcd_data;
        w.rs   = lcd_rs;
        w.rise = cur_rise;
        w.fall = cyc;
        wr_q.push_back(w);
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_en   = lcd_en;
      prev_done = done;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      step();
      k++;
    end
    chk({tag, "_done_within_bound"}, int'(done), 1);
  endtask

  task automatic check_run(input string tag, input int base, input int first, input int n);
    chk({tag, "_nwrites"}, wr_q.size() - base, n);
    for (int i = 0; i < n && base + i < wr_q.size(); i++) begin
      wr_t  w;
      vec_t e;
      w = wr_q[base + i];
      e = exp_tab[first + i];
      chk($sformatf("%s_data%0d", tag, i), int'(w.data), int'(e.data));
      chk($sformatf("%s_rs%0d", tag, i), int'(w.rs), int'(e.rs));
      chk($sformatf("%s_en_high%0d", tag, i), w.fall - w.rise, P_EN);
      if (e.data == 8'h01 && !e.rs && base + i + 1 < wr_q.size())
        chk($sformatf("%s_clear_gap", tag), wr_q[base + i + 1].rise - w.fall, P_CLR + 1 + P_SET);
    end
  endtask

  initial begin
    int rel;
    int base;
    int s;
    int k;

    exp_tab[0]  = '{8'h38, 1'b0};
    exp_tab[1]  = '{8'h0C, 1'b0};
    exp_tab[2]  = '{8'h01, 1'b0};
    exp_tab[3]  = '{8'h06, 1'b0};
    exp_tab[4]  = '{8'h80, 1'b0};
    for (int i = 0; i < 16; i++) exp_tab[5 + i] = '{8'(8'h41 + i), 1'b1};
    exp_tab[21] = '{8'hC0, 1'b0};
    for (int i = 16; i < 32; i++) exp_tab[6 + i] = '{8'(8'h41 + i), 1'b1};

    repeat (3) step();
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_en", int'(lcd_en), 0);
    chk("rst_lcd_on", int'(lcd_on), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);

    rst_n = 1'b1;
    rel   = cyc;
    base  = wr_q.size();
    step();
    chk("lcd_on_after_release", int'(lcd_on), 1);
    chk("lcd_en_after_release", int'(lcd_en), 0);
    repeat (98) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("init", 2000);
    chk("init_done_cycle", done_cyc - rel, 592);
    if (wr_q.size() > base) chk("first_en_rise_cycle", wr_q[base].rise - rel, P_PWR + 1 + P_SET);
    check_run("init", base, 0, 38);
    chk("done_busy", int'(busy), 0);
    chk("done_rom_addr", int'(rom_addr), 31);
    chk("done_lcd_en", int'(lcd_en), 0);
    chk("done_lcd_data", int'(lcd_data), 8'h60);
    chk("done_lcd_rs", int'(lcd_rs), 1);
    repeat (5) step();
    chk("done_held", int'(done), 1);

    base  = wr_q.size();
    start = 1'b1;
    s     = cyc + 1;
    step();
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    chk("restart_done", int'(done), 0);
    chk("restart_rom_addr", int'(rom_addr), 0);
    wait_done("restart", 2000);
    chk("restart_done_cycle", done_cyc - s, 34 * (1 + P_SET + P_EN + P_DLY));
    check_run("restart", base, 4, 34);
    chk("restart_rom_addr_end", int'(rom_addr), 31);

    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!lcd_en && k < 100) begin
      step();
      k++;
    end
    chk("midrst_en_seen", int'(lcd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_lcd_en", int'(lcd_en), 0);
    chk("midrst_lcd_on", int'(lcd_on), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    repeat (3) step();
    rst_n = 1'b1;
    rel   = cyc;
    base  = wr_q.size();
    wait_done("rerun", 2000);
    chk("rerun_done_cycle", done_cyc - rel, 592);
    check_run("rerun", base, 0, 38);

    chk("invariants_busy_done_addr_rw_stable", inv_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
